// File: rtl/pwm_width_meter.sv
// Measures the high and low phase lengths of each complete PWM period on an
// asynchronous input and publishes them as signed 16-bit words with a strobe.
module pwm_width_meter #(
   parameter int TIMEOUT = 32767
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               pwm_in,
   output logic signed [15:0] high_width,
   output logic signed [15:0] low_width,
   output logic               width_valid,
   output logic               timeout,
   output logic [1:0]         fsm_state
);

   typedef enum logic [1:0] {
      WAIT_SYNC = 2'd0,
      MEAS_HIGH = 2'd1,
      MEAS_LOW  = 2'd2
   } state_t;

   localparam logic        TO_EN   = (TIMEOUT != 0);
   localparam logic [14:0] TO_VAL  = 15'(TIMEOUT);
   localparam logic [14:0] CNT_MAX = 15'h7fff;

   state_t      state;
   logic        s1, s2, s3;
   logic [14:0] hcnt, lcnt;
   logic        rise, fall;

   assign rise      = s2 & ~s3;
   assign fall      = ~s2 & s3;
   assign fsm_state = state;

   // An edge always wins over the timeout, so it is tested first in each phase.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         state       <= WAIT_SYNC;
         hcnt        <= '0;
         lcnt        <= '0;
         high_width  <= '0;
         low_width   <= '0;
         width_valid <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         s1          <= pwm_in;
         s2          <= s1;
         s3          <= s2;
         width_valid <= 1'b0;
         timeout     <= 1'b0;
         case (state)
            WAIT_SYNC: begin
               if (rise) begin
                  hcnt  <= 15'd1;
                  state <= MEAS_HIGH;
               end
            end
            MEAS_HIGH: begin
               if (fall) begin
                  lcnt  <= 15'd1;
                  state <= MEAS_LOW;
               end else if (TO_EN && hcnt == TO_VAL) begin
                  timeout <= 1'b1;
                  hcnt    <= '0;
                  lcnt    <= '0;
                  state   <= WAIT_SYNC;
               end else if (hcnt != CNT_MAX) begin
                  hcnt <= hcnt + 15'd1;
               end
            end
            MEAS_LOW: begin
               if (rise) begin
                  high_width  <= {1'b0, hcnt};
                  low_width   <= {1'b0, lcnt};
                  width_valid <= 1'b1;
                  hcnt        <= 15'd1;
                  state       <= MEAS_HIGH;
               end else if (TO_EN && lcnt == TO_VAL) begin
                  timeout <= 1'b1;
                  hcnt    <= '0;
                  lcnt    <= '0;
                  state   <= WAIT_SYNC;
               end else if (lcnt != CNT_MAX) begin
                  lcnt <= lcnt + 15'd1;
               end
            end
            default: state <= WAIT_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_width_meter.sv
// Directed bench: one meter with TIMEOUT=100 and one with the timeout disabled,
// both fed the same PWM line.
module tb_pwm_width_meter;

   logic               clock = 1'b0;
   logic               reset_n = 1'b0;
   logic               pwm_in = 1'b0;
   logic signed [15:0] a_high, a_low, b_high, b_low;
   logic               a_valid, a_to, b_valid, b_to;
   logic [1:0]         a_state, b_state;

   int errors = 0;
   int checks = 0;

   int cyc = 0;
   int a_vld_cnt = 0, a_to_cnt = 0, b_vld_cnt = 0, b_to_cnt = 0;
   int a_last_vld_cyc = 0, a_gap = 0, a_to_cyc = 0;
   int a_dbl = 0, both_cnt = 0;
   logic a_prev_valid = 1'b0;

   pwm_width_meter #(.TIMEOUT(100)) dut_a (
      .clock(clock), .reset_n(reset_n), .pwm_in(pwm_in),
      .high_width(a_high), .low_width(a_low),
      .width_valid(a_valid), .timeout(a_to), .fsm_state(a_state)
   );

   pwm_width_meter #(.TIMEOUT(0)) dut_b (
      .clock(clock), .reset_n(reset_n), .pwm_in(pwm_in),
      .high_width(b_high), .low_width(b_low),
      .width_valid(b_valid), .timeout(b_to), .fsm_state(b_state)
   );

   always #5 clock = ~clock;

   // Strobe bookkeeping sampled on the falling edge, away from the active edge.
   always @(negedge clock) begin
      cyc = cyc + 1;
      if (a_valid) begin
         a_vld_cnt = a_vld_cnt + 1;
         a_gap = cyc - a_last_vld_cyc;
         a_last_vld_cyc = cyc;
         if (a_prev_valid) a_dbl = a_dbl + 1;
      end
      a_prev_valid = a_valid;
      if (a_to) begin
         a_to_cnt = a_to_cnt + 1;
         a_to_cyc = cyc;
      end
      if (b_valid) b_vld_cnt = b_vld_cnt + 1;
      if (b_to) b_to_cnt = b_to_cnt + 1;
      if ((a_valid && a_to) || (b_valid && b_to)) both_cnt = both_cnt + 1;
   end

   // Called at a falling edge; the level is seen by exactly n sampling edges.
   task automatic drive(input logic level, input int n);
      pwm_in = level;
      repeat (n) @(negedge clock);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clock);
      checks++; if (a_high !== 16'sd0 || a_low !== 16'sd0) begin errors++; $display("FAIL reset_widths: got %0d/%0d want 0/0", a_high, a_low); end
      checks++; if (a_valid !== 1'b0 || a_to !== 1'b0 || b_valid !== 1'b0 || b_to !== 1'b0) begin errors++; $display("FAIL reset_strobes: got v=%b t=%b want 0/0", a_valid, a_to); end
      checks++; if (a_state !== 2'd0 || b_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", a_state); end
      reset_n = 1'b1;
   endtask

   task automatic test_basic();
      int base;
      logic signed [15:0] diff;
      base = a_vld_cnt;
      drive(1'b0, 5);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 10);
         drive(1'b0, 20);
      end
      drive(1'b1, 10);
      checks++; if (a_vld_cnt - base !== 3) begin errors++; $display("FAIL basic_count: got %0d want 3", a_vld_cnt - base); end
      checks++; if (a_high !== 16'sd10 || a_low !== 16'sd20) begin errors++; $display("FAIL basic_widths: got %0d/%0d want 10/20", a_high, a_low); end
      checks++; if (a_gap !== 30) begin errors++; $display("FAIL basic_period: got %0d want 30", a_gap); end
      diff = a_high - a_low;
      checks++; if (diff !== -16'sd10) begin errors++; $display("FAIL basic_diff: got %0d want -10", diff); end
      checks++; if (b_high !== 16'sd10 || b_low !== 16'sd20) begin errors++; $display("FAIL basic_widths_b: got %0d/%0d want 10/20", b_high, b_low); end
      drive(1'b0, 20);
   endtask

   task automatic test_duty_change();
      int base;
      base = a_vld_cnt;
      drive(1'b1, 25);
      checks++; if (a_high !== 16'sd10 || a_low !== 16'sd20) begin errors++; $display("FAIL duty_held: got %0d/%0d want 10/20", a_high, a_low); end
      drive(1'b0, 5);
      checks++; if (a_high !== 16'sd10 || a_low !== 16'sd20) begin errors++; $display("FAIL duty_held2: got %0d/%0d want 10/20", a_high, a_low); end
      drive(1'b1, 25);
      checks++; if (a_high !== 16'sd25 || a_low !== 16'sd5) begin errors++; $display("FAIL duty_widths: got %0d/%0d want 25/5", a_high, a_low); end
      checks++; if (a_vld_cnt - base !== 2) begin errors++; $display("FAIL duty_count: got %0d want 2", a_vld_cnt - base); end
      checks++; if (a_gap !== 30) begin errors++; $display("FAIL duty_period: got %0d want 30", a_gap); end
      drive(1'b0, 5);
   endtask

   task automatic test_min_pulse();
      int base;
      base = a_vld_cnt;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1);
         drive(1'b0, 1);
      end
      drive(1'b1, 1);
      drive(1'b0, 3);
      checks++; if (a_vld_cnt - base !== 9) begin errors++; $display("FAIL min_count: got %0d want 9", a_vld_cnt - base); end
      checks++; if (a_high !== 16'sd1 || a_low !== 16'sd1) begin errors++; $display("FAIL min_widths: got %0d/%0d want 1/1", a_high, a_low); end
      checks++; if (a_gap !== 2) begin errors++; $display("FAIL min_period: got %0d want 2", a_gap); end
   endtask

   task automatic test_timeout();
      int vbase, tbase, bbase, t0;
      vbase = a_vld_cnt;
      tbase = a_to_cnt;
      bbase = b_to_cnt;
      t0 = cyc;
      drive(1'b0, 150);
      checks++; if (a_to_cnt - tbase !== 1) begin errors++; $display("FAIL to_count: got %0d want 1", a_to_cnt - tbase); end
      checks++; if (a_to_cyc - t0 < 95 || a_to_cyc - t0 > 105) begin errors++; $display("FAIL to_delay: got %0d want 95..105", a_to_cyc - t0); end
      checks++; if (b_to_cnt - bbase !== 0) begin errors++; $display("FAIL to_disabled: got %0d want 0", b_to_cnt - bbase); end
      checks++; if (a_high !== 16'sd1 || a_low !== 16'sd1) begin errors++; $display("FAIL to_held: got %0d/%0d want 1/1", a_high, a_low); end
      checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL to_state: got %0d want 0", a_state); end
      drive(1'b1, 10);
      drive(1'b0, 20);
      checks++; if (a_vld_cnt - vbase !== 0) begin errors++; $display("FAIL to_resync: got %0d want 0", a_vld_cnt - vbase); end
      drive(1'b1, 10);
      checks++; if (a_vld_cnt - vbase !== 1 || a_high !== 16'sd10 || a_low !== 16'sd20) begin errors++; $display("FAIL to_relock: got n=%0d %0d/%0d want n=1 10/20", a_vld_cnt - vbase, a_high, a_low); end
   endtask

   task automatic test_saturate();
      int atb, btb, avb;
      drive(1'b0, 3);
      atb = a_to_cnt;
      btb = b_to_cnt;
      avb = a_vld_cnt;
      drive(1'b1, 40000);
      drive(1'b0, 3);
      drive(1'b1, 5);
      checks++; if (b_high !== 16'sd32767 || b_low !== 16'sd3) begin errors++; $display("FAIL sat_widths: got %0d/%0d want 32767/3", b_high, b_low); end
      checks++; if (b_to_cnt - btb !== 0) begin errors++; $display("FAIL sat_no_timeout: got %0d want 0", b_to_cnt - btb); end
      checks++; if (a_to_cnt - atb !== 1) begin errors++; $display("FAIL sat_high_timeout: got %0d want 1", a_to_cnt - atb); end
      checks++; if (a_vld_cnt - avb !== 1 || a_high !== 16'sd10 || a_low !== 16'sd3) begin errors++; $display("FAIL sat_a_held: got n=%0d %0d/%0d want n=1 10/3", a_vld_cnt - avb, a_high, a_low); end
   endtask

   task automatic test_reset_mid();
      int avb, bvb;
      drive(1'b0, 7);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (a_high !== 16'sd0 || a_low !== 16'sd0 || b_high !== 16'sd0 || b_low !== 16'sd0) begin errors++; $display("FAIL rst_async: got %0d/%0d %0d/%0d want 0", a_high, a_low, b_high, b_low); end
      checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", a_state); end
      @(negedge clock);
      reset_n = 1'b1;
      avb = a_vld_cnt;
      bvb = b_vld_cnt;
      drive(1'b1, 10);
      drive(1'b0, 10);
      checks++; if (a_vld_cnt - avb !== 0 || b_vld_cnt - bvb !== 0) begin errors++; $display("FAIL rst_no_early: got %0d/%0d want 0/0", a_vld_cnt - avb, b_vld_cnt - bvb); end
      pwm_in = 1'b1;
      @(negedge clock);
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_k: got %b want 0", a_valid); end
      @(negedge clock);
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL lat_k1: got %b want 0", a_valid); end
      @(negedge clock);
      checks++; if (a_valid !== 1'b1 || a_high !== 16'sd10 || a_low !== 16'sd10) begin errors++; $display("FAIL lat_k2: got v=%b %0d/%0d want v=1 10/10", a_valid, a_high, a_low); end
      drive(1'b1, 3);
   endtask

   initial begin
      @(negedge clock);
      test_reset();
      test_basic();
      test_duty_change();
      test_min_pulse();
      test_timeout();
      test_saturate();
      test_reset_mid();
      checks++; if (both_cnt !== 0) begin errors++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
      checks++; if (a_dbl !== 0) begin errors++; $display("FAIL valid_width: got %0d want 0", a_dbl); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: got timeout want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pwm_width_meter.md
Name: pwm_width_meter

Overview:
- Front-end stage of the PWM decoder, directly upstream of the signed 16-bit subtractor.
- Synchronises the raw PWM input and measures the high-phase and low-phase durations of each complete PWM period in clock cycles.
- Publishes both durations as signed 16-bit words with a one-cycle valid strobe.
- The subtractor consumes high_width as input_one and low_width as input_two, so high minus low gives the signed demodulated sample.

Parameters:
- TIMEOUT, 32767, cycles without an edge before the measurement is abandoned. 0 disables the timeout. Legal range 0..32767.

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- pwm_in  input  1  raw PWM line, asynchronous to clock
- high_width  output  16  signed; high-phase length of the last complete period, in cycles
- low_width  output  16  signed; low-phase length of the last complete period, in cycles
- width_valid  output  1  one-cycle strobe; high_width/low_width updated this cycle
- timeout  output  1  one-cycle strobe; measurement abandoned due to no edge

Behaviour:
- Interface (already decided): one clock, `clock`; reset `reset_n` is asynchronous and active-low. Assertion immediately clears all state; release is synchronous to `clock`.
- Reset values: high_width=0, low_width=0, width_valid=0, timeout=0, synchroniser flops=0, state=WAIT_SYNC, counters=0.
- Synchroniser: two flops s1, s2 on pwm_in, plus one history flop s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - No other logic samples pwm_in directly.
- Counters: hcnt and lcnt, 15-bit unsigned magnitude, saturating at 32767 (no wrap). Outputs are zero-extended to signed 16, so they are always >= 0.
- State machine:
  - WAIT_SYNC: counters idle. On rise: hcnt<=1 -> MEAS_HIGH. Any fall is ignored. The first partial period after reset or timeout is never published.
  - MEAS_HIGH: on fall, lcnt<=1 -> MEAS_LOW. Otherwise hcnt saturating +1.
  - MEAS_LOW: on rise, high_width<=hcnt, low_width<=lcnt, width_valid<=1, hcnt<=1 -> MEAS_HIGH. Otherwise lcnt saturating +1.
- Timeout (TIMEOUT != 0): in MEAS_HIGH or MEAS_LOW, if the active counter == TIMEOUT and no edge occurs this cycle:
  - timeout<=1 for one cycle;
  - -> WAIT_SYNC;
  - high_width/low_width hold their previous values; width_valid stays 0.
- Simultaneous events: an edge in the same cycle as the timeout condition takes priority; the edge is processed and no timeout fires.
- Latency: pin transition sampled on clock edge k gives rise/fall combinationally during cycle k+2. The resulting register updates (width_valid, outputs) are visible after edge k+2.
- Counting: a stable high level spanning N sampling edges yields hcnt=N, exactly. Minimum measurable phase is 1 cycle.
- width_valid and timeout are never asserted together. Both are 0 whenever not explicitly strobed.
- Outputs are registered and stable between strobes; no handshake or back-pressure. The downstream subtractor samples them every cycle.
- Reset mid-measurement: everything returns to reset values. The next published period requires a full rise-fall-rise after release.

Test Plan:
- After reset, drive pwm_in high 10 / low 20 cycles repeatedly -> first width_valid occurs at the second rise (first period discarded); then high_width=10, low_width=20 every 30 cycles; downstream subtractor shows -10.
- Duty change: 25 high / 5 low following 10/20 -> next strobe reports 25/5, the previous values held until then, single-cycle width_valid.
- Minimum pulses: high 1 / low 1 alternating -> high_width=1, low_width=1, width_valid every 2 cycles after lock.
- TIMEOUT=100, pwm_in held low 150 cycles mid-stream -> exactly one timeout pulse ~100 cycles after the fall, outputs unchanged, no width_valid until a full new period is seen.
- TIMEOUT=0, high 40000 / low 3 -> high_width=32767 (saturated), low_width=3, no timeout.
- reset_n pulsed low during MEAS_LOW -> outputs go 0 asynchronously; the first post-reset strobe only after a complete rise-fall-rise.
